// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes and
// whole-pipe freeze while a multi-cycle data memory access is outstanding.
module pipe_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_uses_rt,
    input  logic             br_taken,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic             pipe_freeze,
    output logic             memwb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam int WC_W = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(WAIT_MAX);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            timeout_set;

    logic [REG_W-1:0] rs, rt;
    logic             mw, lu, wait_expired;
    logic             freeze_all, advance;
    logic             unused_instr_bits;

    assign rs = id_instr[21 +: REG_W];
    assign rt = id_instr[16 +: REG_W];
    assign unused_instr_bits = ^{id_instr[31:26], id_instr[15:0]};

    assign mw = mem_req & ~mem_ready;
    assign lu = exe_mem_read && (exe_dest != '0) &&
                ((exe_dest == rs) || (id_uses_rt && (exe_dest == rt)));
    assign wait_expired = (wait_cnt >= WAIT_LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set)
                mem_timeout <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // infer a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        unique case (state)
            RUN: begin
                if (mw) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (!wait_expired) begin
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    timeout_set  = 1'b1;
                end
            end
        endcase
    end

    // Freeze dominates load-use, which dominates the branch flush.
    always_comb begin
        pc_freeze    = 1'b0;
        ifid_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        idexe_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        memwb_bubble = 1'b0;
        freeze_all   = 1'b0;
        advance      = 1'b0;
        unique case (state)
            RUN: begin
                if (mw) freeze_all = 1'b1;
                else    advance    = 1'b1;
            end
            MEM_WAIT: begin
                if (mem_ready)          advance      = 1'b1;
                else if (!wait_expired) freeze_all   = 1'b1;
                else                    memwb_bubble = 1'b1;
            end
        endcase
        if (freeze_all) begin
            pc_freeze    = 1'b1;
            ifid_freeze  = 1'b1;
            pipe_freeze  = 1'b1;
            memwb_bubble = 1'b1;
        end
        if (advance) begin
            if (lu) begin
                pc_freeze    = 1'b1;
                ifid_freeze  = 1'b1;
                idexe_bubble = 1'b1;
            end else if (br_taken) begin
                ifid_flush = 1'b1;
            end
        end
        if (rst) begin
            pc_freeze    = 1'b0;
            ifid_freeze  = 1'b0;
            ifid_flush   = 1'b0;
            idexe_bubble = 1'b0;
            pipe_freeze  = 1'b0;
            memwb_bubble = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_freeze && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_MAX=4, CNT_W=4 so
// timeout and counter saturation are reachable quickly).
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      id_instr;
    logic             id_uses_rt, br_taken, exe_mem_read, mem_req, mem_ready;
    logic [REG_W-1:0] exe_dest;
    logic             pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, pipe_freeze, memwb_bubble;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;
    logic [5:0]       ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_uses_rt(id_uses_rt),
        .br_taken(br_taken), .exe_mem_read(exe_mem_read), .exe_dest(exe_dest),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze),
        .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush), .idexe_bubble(idexe_bubble),
        .pipe_freeze(pipe_freeze), .memwb_bubble(memwb_bubble), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // {pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, pipe_freeze, memwb_bubble}
    assign ctrl = {pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, pipe_freeze, memwb_bubble};

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b110100;
    localparam logic [5:0] C_FLUSH  = 6'b001000;
    localparam logic [5:0] C_FREEZE = 6'b110011;
    localparam logic [5:0] C_WBNOP  = 6'b000001;

    function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 16'd0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        id_instr = '0; id_uses_rt = 0; br_taken = 0; exe_mem_read = 0;
        exe_dest = '0; mem_req = 0; mem_ready = 0;
    endtask

    // Inputs are applied at posedge+1; control checked 1 ns later, counters after the next edge.
    task automatic step(input string tag, input logic [5:0] exp_ctrl, input int exp_stall,
                        input int exp_flush, input logic exp_to);
        #1;
        check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
        @(posedge clk); #1;
        check({tag, "_stall"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_flush"}, 32'(flush_cnt), 32'(exp_flush));
        check({tag, "_to"}, 32'(mem_timeout), 32'(exp_to));
    endtask

    // Asserted off-edge: everything must clear without a clock edge.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_ctrl"}, 32'(ctrl), 32'(C_NONE));
        check({tag, "_stall"}, 32'(stall_cnt), 0);
        check({tag, "_flush"}, 32'(flush_cnt), 0);
        check({tag, "_to"}, 32'(mem_timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        br_taken = 1'b1;
        exe_mem_read = 1'b1; exe_dest = 5'd3; id_instr = mk_instr(5'd3, 5'd0);
        #3;
        check("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        check("rst_stall", 32'(stall_cnt), 0);
        check("rst_flush", 32'(flush_cnt), 0);
        check("rst_to", 32'(mem_timeout), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();

        // Load-use and branch interaction
        exe_mem_read = 1; exe_dest = 5'd3; id_instr = mk_instr(5'd3, 5'd0);
        step("lu_rs", C_LU, 1, 0, 0);
        br_taken = 1;
        step("lu_br", C_LU, 2, 0, 0);
        br_taken = 0; exe_dest = 5'd0; id_instr = mk_instr(5'd0, 5'd0);
        step("lu_r0", C_NONE, 2, 0, 0);
        exe_dest = 5'd5; id_instr = mk_instr(5'd1, 5'd5); id_uses_rt = 0;
        step("lu_rt_nouse", C_NONE, 2, 0, 0);
        id_uses_rt = 1;
        step("lu_rt_use", C_LU, 3, 0, 0);
        exe_mem_read = 0; br_taken = 1;
        step("br_flush", C_FLUSH, 3, 1, 0);
        br_taken = 0;
        step("idle", C_NONE, 3, 1, 0);

        // Memory wait released by mem_ready
        reset_pulse("rst_a");
        mem_req = 1; mem_ready = 0;
        step("mw_run", C_FREEZE, 1, 0, 0);
        exe_mem_read = 1; exe_dest = 5'd3; id_instr = mk_instr(5'd3, 5'd0);
        step("mw_w1_lu", C_FREEZE, 2, 0, 0);
        exe_mem_read = 0;
        step("mw_w2", C_FREEZE, 3, 0, 0);
        mem_ready = 1;
        step("mw_ready", C_NONE, 3, 0, 0);
        mem_req = 0; mem_ready = 0;
        step("mw_back_run", C_NONE, 3, 0, 0);

        // Timeout after WAIT_MAX, then async reset mid-wait
        reset_pulse("rst_b");
        mem_req = 1; mem_ready = 0;
        step("to_run", C_FREEZE, 1, 0, 0);
        step("to_w1", C_FREEZE, 2, 0, 0);
        step("to_w2", C_FREEZE, 3, 0, 0);
        step("to_w3", C_FREEZE, 4, 0, 0);
        step("to_release", C_WBNOP, 4, 0, 1);
        mem_req = 0;
        step("to_sticky", C_NONE, 4, 0, 1);
        mem_req = 1;
        step("to2_run", C_FREEZE, 5, 0, 1);
        step("to2_w1", C_FREEZE, 6, 0, 1);
        reset_pulse("rst_midwait");
        step("post_rst_run", C_NONE, 0, 0, 0);

        // Flush counter saturation: 2^CNT_W + 5 flushes
        reset_pulse("rst_c");
        br_taken = 1;
        #1;
        check("sat_ctrl", 32'(ctrl), 32'(C_FLUSH));
        repeat ((1 << CNT_W) + 5) @(posedge clk);
        #1;
        check("sat_flush", 32'(flush_cnt), 32'((1 << CNT_W) - 1));
        check("sat_stall", 32'(stall_cnt), 0);
        br_taken = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
